mac_operand_loader: RTL and testbench
=====================================

Name: mac_operand_loader

Overview:
Wishbone-slave front end that sits directly upstream of the MAC unit.
- Firmware writes eight 32-bit operand words, which the block assembles into the 256-bit MAC input vector.
- It issues that vector to the MAC with a valid/ready handshake and captures the 28-bit MAC result.
- Firmware polls the result over Wishbone, or takes an interrupt when IRQ support is compiled in.
- Replaces the direct logic-analyser feed of the MAC input.

Parameters:
- BASE_ADDR, 32'h3000_0000, block base address; decode compares adr[31:8] against BASE_ADDR[31:8].
- DW, 256, operand vector width; must be a multiple of 32.
- RW, 28, MAC result width; must be at most 32.
- NWORDS, DW/32 (8), number of operand words.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge, registered.
- wbs_dat_o  out  32  read data, registered.
- op_data_o  out  DW  operand vector to the MAC; word n occupies bits [32n+31:32n].
- op_valid_o  out  1  operand vector valid.
- op_ready_i  in  1  MAC accepts the operand vector.
- res_data_i  in  RW  MAC result.
- res_valid_i  in  1  MAC result valid, one-cycle pulse.
- irq_o  out  1  done interrupt (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state=IDLE; wbs_ack_o, wbs_dat_o, op_valid_o, irq_o, op_data_o, result, load mask and status flags all 0.
- Wishbone access: a cycle is selected when stb&cyc&!ack and the address decodes.
  - wbs_ack_o pulses exactly one cycle, on the cycle after selection, so there is one wait state and never a back-to-back ack.
  - Read data is registered together with ack.
  - Unmapped offsets: reads return 0, writes are dropped; both are still acked.
  - Addresses outside the block are never acked.
- Register map (offset adr[7:2]):
  - 0x00-0x1C DATA0-7: RW, byte-lane writes honour wbs_sel_i.
  - 0x20 CTRL: W. [0] START, [1] KEEP (sticky config), [2] ABORT. Reads return {30'b0, KEEP, 1'b0}.
  - 0x24 STATUS: RO. [0] busy, [1] full, [2] done, [3] err, [10:8] state, [23:16] load mask.
  - 0x28 RESULT: RO, zero-extended result.
- Load mask: a write to DATAn with any sel bit set sets mask[n]. full = &mask.
- FSM states and transitions:
  - IDLE: DATA writes accepted. START with full moves to ISSUE next cycle. START without full is ignored and sets err.
  - ISSUE: op_valid_o=1 and op_data_o held stable. On op_valid_o&op_ready_i, go to WAIT_RES; op_valid_o deasserts the following cycle. No timeout.
  - WAIT_RES: on res_valid_i, capture res_data_i into RESULT, set done, go to DONE.
  - DONE: a read of RESULT clears done and returns to IDLE. Mask is cleared unless KEEP=1; with KEEP=1, a new START reissues the same vector.
- DATA writes outside IDLE are dropped and set err. START outside IDLE is ignored and sets err.
- ABORT from any state: next state IDLE, op_valid_o=0, mask cleared, done cleared; RESULT is retained. ABORT wins over START in the same write.
- res_valid_i outside WAIT_RES is ignored. A result arriving in the same cycle as a RESULT read returns the old value; the new value is visible on the next read.
- err is sticky; it is cleared by writing STATUS with bit3=1 (write-1-to-clear, the only writable STATUS bit).
- busy = state is ISSUE or WAIT_RES.
- Reset mid-handshake drops op_valid_o immediately (asynchronous).

Optional Feature:
- Macro: MAC_LDR_IRQ_EN.
- Defined:
  - irq_o is a level output equal to done & CTRL[3] (IRQ enable bit, RW, reset 0).
  - irq_o clears together with done.
  - CTRL reads return bit3.
- Undefined:
  - irq_o is tied 0.
  - CTRL[3] reads 0 and writes to it are ignored.

Test Plan:
- Reset with wb_rst_ni=0 mid-ISSUE -> op_valid_o=0, STATUS=0, RESULT=0 immediately and after release.
- Write DATA0-7 = 32'h0101_0101*(n+1), then START; MAC model holds ready=0 for 3 cycles -> op_valid_o stays high with op_data_o[31:0]=32'h0101_0101 and [255:224]=32'h0808_0808; after the handshake op_valid_o drops and STATUS.state=WAIT_RES.
- res_data_i=28'hABC_DEF0 pulsed in WAIT_RES -> STATUS.done=1; RESULT reads 32'h0ABC_DEF0; next STATUS read shows done=0, state=IDLE, mask=0.
- Write DATA0-6 only, then START -> no op_valid_o, err=1; write STATUS bit3 -> err=0.
- Byte write to DATA2 with sel=4'b0100, data=32'h00FF_0000 over 32'h1122_3344 -> DATA2 reads 32'h11FF_3344; during busy, a DATA write is acked but dropped and err=1.
- With KEEP=1 run two STARTs back to back, then ABORT during ISSUE -> second vector identical to first; ABORT gives op_valid_o=0 next cycle, mask=0, and with MAC_LDR_IRQ_EN and CTRL[3]=1 irq_o pulses high only while done=1.

Source files
------------

// File: rtl/mac_operand_loader.sv
// mac_operand_loader: Wishbone-slave front end for the MAC unit.
//
// Firmware writes NWORDS 32-bit operand words (DATA0..DATA7), which are assembled into the
// DW-bit MAC input vector. A START issues that vector with a valid/ready handshake. The
// RW-bit MAC result is captured and then polled over Wishbone.
//
// Register map (offset = adr[7:2]):
//   0x00-0x1C DATA0-7  RW, byte lanes honour wbs_sel_i
//   0x20      CTRL     W: [0] START, [1] KEEP, [2] ABORT, [3] IRQ enable
//                      R: {KEEP at bit 1, IRQ enable at bit 3}
//   0x24      STATUS   RO except bit 3 (W1C err):
//                      [0] busy [1] full [2] done [3] err [10:8] state [23:16] load mask
//   0x28      RESULT   RO, zero-extended result
//
// Ports:
//   wb_clk_i, wb_rst_ni      clock, asynchronous active-low reset
//   wbs_*                    Wishbone slave (registered ack and read data, one wait state)
//   op_data_o/op_valid_o/op_ready_i   operand vector handshake to the MAC
//   res_data_i/res_valid_i   MAC result, one-cycle valid pulse
//   irq_o                    done interrupt
//
// Build option: define MAC_LDR_IRQ_EN to enable CTRL[3] and irq_o; otherwise irq_o is tied 0
// and CTRL[3] reads 0.
module mac_operand_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned DW        = 256,
   parameter int unsigned RW        = 28
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic          wbs_stb_i,
   input  logic          wbs_cyc_i,
   input  logic          wbs_we_i,
   input  logic [3:0]    wbs_sel_i,
   input  logic [31:0]   wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   output logic          wbs_ack_o,
   output logic [31:0]   wbs_dat_o,
   output logic [DW-1:0] op_data_o,
   output logic          op_valid_o,
   input  logic          op_ready_i,
   input  logic [RW-1:0] res_data_i,
   input  logic          res_valid_i,
   output logic          irq_o
);

   localparam int unsigned NWORDS = DW / 32;

   localparam logic [5:0] OffCtrl   = 6'h08;
   localparam logic [5:0] OffStatus = 6'h09;
   localparam logic [5:0] OffResult = 6'h0A;

   // Encoding is visible to firmware in STATUS[10:8].
   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StIssue   = 3'd1,
      StWaitRes = 3'd2,
      StDone    = 3'd3
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       data_q [NWORDS];
   logic [31:0]       data_d [NWORDS];
   logic [NWORDS-1:0] mask_q, mask_d;
   logic              keep_q, keep_d;
   logic              err_q, err_d;
   logic [RW-1:0]     result_q, result_d;
   logic              ack_q;
   logic [31:0]       rdata_q, rdata_d;
   logic              ien_q;
`ifdef MAC_LDR_IRQ_EN
   logic              ien_d;
`endif

   logic        sel, wr, rd, is_data, full, busy, done;
   logic [5:0]  off;
   logic [7:0]  mask_field;
   logic [31:0] result_ext, status_rd;
   logic        unused_adr;

   assign off        = wbs_adr_i[7:2];
   assign unused_adr = ^wbs_adr_i[1:0];
   // !ack_q blocks reselection on the ack cycle, so acks are never back to back.
   assign sel     = wbs_stb_i & wbs_cyc_i & ~ack_q & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign wr      = sel & wbs_we_i;
   assign rd      = sel & ~wbs_we_i;
   assign is_data = off < 6'(NWORDS);

   assign full = &mask_q;
   assign busy = (state_q == StIssue) || (state_q == StWaitRes);
   assign done = (state_q == StDone);

   always_comb begin
      mask_field = '0;
      mask_field[NWORDS-1:0] = mask_q;
      result_ext = '0;
      result_ext[RW-1:0] = result_q;
      status_rd = '0;
      status_rd[0]     = busy;
      status_rd[1]     = full;
      status_rd[2]     = done;
      status_rd[3]     = err_q;
      status_rd[10:8]  = state_q;
      status_rd[23:16] = mask_field;
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      mask_d   = mask_q;
      keep_d   = keep_q;
      err_d    = err_q;
      result_d = result_q;
      rdata_d  = '0;
`ifdef MAC_LDR_IRQ_EN
      ien_d    = ien_q;
`endif

      // MAC side; results outside StWaitRes are ignored.
      case (state_q)
         StIssue:   if (op_ready_i) state_d = StWaitRes;
         StWaitRes: begin
            if (res_valid_i) begin
               result_d = res_data_i;
               state_d  = StDone;
            end
         end
         default: ;
      endcase

      if (wr) begin
         if (is_data) begin
            if (state_q == StIdle) begin
               for (int unsigned i = 0; i < NWORDS; i++) begin
                  if (off == 6'(i)) begin
                     for (int unsigned b = 0; b < 4; b++) begin
                        if (wbs_sel_i[b]) data_d[i][8*b +: 8] = wbs_dat_i[8*b +: 8];
                     end
                     if (|wbs_sel_i) mask_d[i] = 1'b1;
                  end
               end
            end else begin
               err_d = 1'b1;
            end
         end else if (off == OffCtrl) begin
            keep_d = wbs_dat_i[1];
`ifdef MAC_LDR_IRQ_EN
            ien_d  = wbs_dat_i[3];
`endif
            // ABORT takes priority over START in the same write.
            if (wbs_dat_i[2]) begin
               state_d = StIdle;
               mask_d  = '0;
            end else if (wbs_dat_i[0]) begin
               if ((state_q == StIdle) && full) state_d = StIssue;
               else                              err_d   = 1'b1;
            end
         end else if (off == OffStatus) begin
            if (wbs_dat_i[3]) err_d = 1'b0;
         end
      end

      if (rd) begin
         if (is_data) begin
            for (int unsigned i = 0; i < NWORDS; i++) begin
               if (off == 6'(i)) rdata_d = data_q[i];
            end
         end else if (off == OffCtrl) begin
            rdata_d = {28'b0, ien_q, 1'b0, keep_q, 1'b0};
         end else if (off == OffStatus) begin
            rdata_d = status_rd;
         end else if (off == OffResult) begin
            // Returns the pre-capture value if a result lands in this same cycle.
            rdata_d = result_ext;
            if (state_q == StDone) begin
               state_d = StIdle;
               if (!keep_q) mask_d = '0;
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q  <= StIdle;
         for (int unsigned i = 0; i < NWORDS; i++) data_q[i] <= '0;
         mask_q   <= '0;
         keep_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
         ack_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         mask_q   <= mask_d;
         keep_q   <= keep_d;
         err_q    <= err_d;
         result_q <= result_d;
         ack_q    <= sel;
         rdata_q  <= rdata_d;
      end
   end

`ifdef MAC_LDR_IRQ_EN
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) ien_q <= 1'b0;
      else            ien_q <= ien_d;
   end
`else
   assign ien_q = 1'b0;
`endif

   always_comb begin
      for (int unsigned i = 0; i < NWORDS; i++) op_data_o[32*i +: 32] = data_q[i];
   end

   assign op_valid_o = (state_q == StIssue);
   assign irq_o      = ien_q & done;
   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = rdata_q;

endmodule

// File: tb/tb_mac_operand_loader.sv
module tb_mac_operand_loader;

   localparam logic [31:0] BASE     = 32'h3000_0000;
   localparam logic [31:0] A_CTRL   = BASE + 32'h20;
   localparam logic [31:0] A_STATUS = BASE + 32'h24;
   localparam logic [31:0] A_RESULT = BASE + 32'h28;
   localparam int S_IDLE = 0, S_ISSUE = 1, S_WAIT = 2, S_DONE = 3;
`ifdef MAC_LDR_IRQ_EN
   localparam logic IRQ_EN = 1'b1;
`else
   localparam logic IRQ_EN = 1'b0;
`endif

   logic         clk, rst_n;
   logic         stb, cyc, we;
   logic [3:0]   sel;
   logic [31:0]  adr, dat_w, dat_r;
   logic         ack;
   logic [255:0] op_data;
   logic         op_valid, op_ready;
   logic [27:0]  res_data;
   logic         res_valid, irq;

   mac_operand_loader dut (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n),
      .wbs_stb_i  (stb),
      .wbs_cyc_i  (cyc),
      .wbs_we_i   (we),
      .wbs_sel_i  (sel),
      .wbs_adr_i  (adr),
      .wbs_dat_i  (dat_w),
      .wbs_ack_o  (ack),
      .wbs_dat_o  (dat_r),
      .op_data_o  (op_data),
      .op_valid_o (op_valid),
      .op_ready_i (op_ready),
      .res_data_i (res_data),
      .res_valid_i(res_valid),
      .irq_o      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state.
   logic [31:0] m_data [8];
   int          n_tests, n_fail;

   function automatic logic [255:0] m_vec();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[32*i +: 32] = m_data[i];
      return v;
   endfunction

   function automatic logic [31:0] exp_status(input int st, input logic [7:0] m, input logic e);
      logic [31:0] v;
      v        = '0;
      v[0]     = (st == S_ISSUE) || (st == S_WAIT);
      v[1]     = (m == 8'hFF);
      v[2]     = (st == S_DONE);
      v[3]     = e;
      v[10:8]  = 3'(st);
      v[23:16] = m;
      return v;
   endfunction

   function automatic logic [31:0] a_data(input int n);
      return BASE + 32'(n * 4);
   endfunction

   // Bus driver: one Wishbone access, bounded wait for ack.
   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdv);
      bit got;
      got = 0;
      rdv = '0;
      @(negedge clk);
      stb = 1; cyc = 1; we = w; adr = a; dat_w = d; sel = s;
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge clk);
         if (ack) begin
            got = 1;
            rdv = dat_r;
         end
      end
      stb = 0; cyc = 0; we = 0;
      if (!got) begin
         n_tests++; n_fail++;
         $display("FAIL bus_timeout adr=%h: ack never seen, required within 4 cycles", a);
      end
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      wb_xfer(1'b1, a, d, s, dummy);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
      wb_xfer(1'b0, a, 32'h0, 4'hF, d);
   endtask

   // MAC model: hold ready low for dly cycles, then accept; returns the vector seen.
   task automatic mac_accept(input int dly, output logic [255:0] seen, output logic vld);
      repeat (dly) @(negedge clk);
      op_ready = 1'b1;
      seen = op_data;
      vld  = op_valid;
      @(negedge clk);
      op_ready = 1'b0;
   endtask

   task automatic mac_result(input logic [27:0] r);
      res_valid = 1'b1;
      res_data  = r;
      @(negedge clk);
      res_valid = 1'b0;
   endtask

   task automatic load_all();
      for (int n = 0; n < 8; n++) wb_write(a_data(n), m_data[n], 4'hF);
   endtask

   task automatic test_reset();
      logic [31:0] rdv;
      n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b want=0", op_valid); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b want=0", irq); end
      n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got=%b want=0", ack); end
      n_tests++; if (dat_r !== 32'h0) begin n_fail++; $display("FAIL rst_dat got=%h want=0", dat_r); end
      n_tests++; if (op_data !== 256'h0) begin n_fail++; $display("FAIL rst_opdata got=%h want=0", op_data); end
      @(negedge clk);
      rst_n = 1'b1;
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== 32'h0) begin n_fail++; $display("FAIL rst_status got=%h want=0", rdv); end
      wb_read(A_RESULT, rdv);
      n_tests++; if (rdv !== 32'h0) begin n_fail++; $display("FAIL rst_result got=%h want=0", rdv); end
      wb_read(A_CTRL, rdv);
      n_tests++; if (rdv !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl got=%h want=0", rdv); end
   endtask

   task automatic test_wb_protocol();
      logic [31:0] rdv;
      int acks;
      logic prev, consec;
      wb_read(BASE + 32'h30, rdv);
      n_tests++; if (rdv !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got=%h want=0", rdv); end
      wb_write(BASE + 32'h2C, 32'hFFFF_FFFF, 4'hF);
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== 32'h0) begin n_fail++; $display("FAIL unmapped_write got=%h want=0", rdv); end
      // Outside the block: never acked.
      @(negedge clk);
      stb = 1; cyc = 1; we = 0; adr = BASE + 32'h100; sel = 4'hF;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ack) acks++;
      end
      stb = 0; cyc = 0;
      n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL out_of_block_acks got=%0d want=0", acks); end
      // Strobe held: ack is a single-cycle pulse, one wait state per access.
      @(negedge clk);
      stb = 1; cyc = 1; we = 0; adr = A_CTRL;
      acks = 0; prev = 0; consec = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ack) acks++;
         if (ack && prev) consec = 1;
         prev = ack;
      end
      stb = 0; cyc = 0;
      n_tests++; if (acks !== 2) begin n_fail++; $display("FAIL ack_count got=%0d want=2", acks); end
      n_tests++; if (consec !== 1'b0) begin n_fail++; $display("FAIL ack_b2b got=%b want=0", consec); end
   endtask

   task automatic test_issue();
      logic [31:0] rdv;
      logic [255:0] seen;
      logic vld;
      for (int n = 0; n < 8; n++) m_data[n] = 32'h0101_0101 * 32'(n + 1);
      load_all();
      wb_write(A_CTRL, 32'h1, 4'hF);
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (op_valid !== 1'b1) begin n_fail++; $display("FAIL issue_valid cyc%0d got=%b want=1", i, op_valid); end
         n_tests++; if (op_data[31:0] !== 32'h0101_0101 || op_data[255:224] !== 32'h0808_0808)
            begin n_fail++; $display("FAIL issue_words got=%h/%h want=01010101/08080808", op_data[31:0], op_data[255:224]); end
         @(negedge clk);
      end
      mac_accept(0, seen, vld);
      n_tests++; if (seen !== m_vec() || vld !== 1'b1) begin n_fail++; $display("FAIL issue_vec got=%h want=%h", seen, m_vec()); end
      n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL issue_drop got=%b want=0", op_valid); end
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== exp_status(S_WAIT, 8'hFF, 1'b0)) begin n_fail++; $display("FAIL wait_status got=%h want=%h", rdv, exp_status(S_WAIT, 8'hFF, 1'b0)); end
      // DATA write while busy: acked, dropped, err set.
      wb_write(a_data(0), 32'hDEAD_BEEF, 4'hF);
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== exp_status(S_WAIT, 8'hFF, 1'b1)) begin n_fail++; $display("FAIL busy_err got=%h want=%h", rdv, exp_status(S_WAIT, 8'hFF, 1'b1)); end
      wb_read(a_data(0), rdv);
      n_tests++; if (rdv !== m_data[0]) begin n_fail++; $display("FAIL busy_drop got=%h want=%h", rdv, m_data[0]); end
      wb_write(A_STATUS, 32'h8, 4'hF);
   endtask

   task automatic test_result();
      logic [31:0] rdv;
      mac_result(28'hABC_DEF0);
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL res_irq_off got=%b want=0", irq); end
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== exp_status(S_DONE, 8'hFF, 1'b0)) begin n_fail++; $display("FAIL done_status got=%h want=%h", rdv, exp_status(S_DONE, 8'hFF, 1'b0)); end
      wb_read(A_RESULT, rdv);
      n_tests++; if (rdv !== 32'h0ABC_DEF0) begin n_fail++; $display("FAIL result got=%h want=0abcdef0", rdv); end
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== exp_status(S_IDLE, 8'h00, 1'b0)) begin n_fail++; $display("FAIL after_read_status got=%h want=%h", rdv, exp_status(S_IDLE, 8'h00, 1'b0)); end
      // Stray result in IDLE is ignored.
      @(negedge clk);
      mac_result(28'h123_4567);
      wb_read(A_RESULT, rdv);
      n_tests++; if (rdv !== 32'h0ABC_DEF0) begin n_fail++; $display("FAIL stray_result got=%h want=0abcdef0", rdv); end
   endtask

   task automatic test_err();
      logic [31:0] rdv;
      logic seen_valid;
      for (int n = 0; n < 7; n++) wb_write(a_data(n), m_data[n], 4'hF);
      wb_write(A_CTRL, 32'h1, 4'hF);
      seen_valid = op_valid;
      repeat (2) begin @(negedge clk); seen_valid |= op_valid; end
      n_tests++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL partial_start_valid got=%b want=0", seen_valid); end
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== exp_status(S_IDLE, 8'h7F, 1'b1)) begin n_fail++; $display("FAIL partial_err got=%h want=%h", rdv, exp_status(S_IDLE, 8'h7F, 1'b1)); end
      wb_write(A_STATUS, 32'h8, 4'hF);
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== exp_status(S_IDLE, 8'h7F, 1'b0)) begin n_fail++; $display("FAIL err_w1c got=%h want=%h", rdv, exp_status(S_IDLE, 8'h7F, 1'b0)); end
   endtask

   task automatic test_byte_write();
      logic [31:0] rdv;
      wb_write(a_data(2), 32'h1122_3344, 4'hF);
      wb_write(a_data(2), 32'h00FF_0000, 4'b0100);
      m_data[2] = 32'h11FF_3344;
      wb_read(a_data(2), rdv);
      n_tests++; if (rdv !== 32'h11FF_3344) begin n_fail++; $display("FAIL byte_lane got=%h want=11ff3344", rdv); end
      // sel=0 write changes nothing and does not mark the word loaded.
      wb_write(a_data(7), 32'hFFFF_FFFF, 4'b0000);
      wb_read(a_data(7), rdv);
      n_tests++; if (rdv !== m_data[7]) begin n_fail++; $display("FAIL sel0_data got=%h want=%h", rdv, m_data[7]); end
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== exp_status(S_IDLE, 8'h7F, 1'b0)) begin n_fail++; $display("FAIL sel0_mask got=%h want=%h", rdv, exp_status(S_IDLE, 8'h7F, 1'b0)); end
      wb_write(a_data(7), 32'h0000_00AA, 4'b0001);
      m_data[7][7:0] = 8'hAA;
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== exp_status(S_IDLE, 8'hFF, 1'b0)) begin n_fail++; $display("FAIL full_mask got=%h want=%h", rdv, exp_status(S_IDLE, 8'hFF, 1'b0)); end
      // START and ABORT together: ABORT wins.
      wb_write(A_CTRL, 32'h5, 4'hF);
      n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL abort_wins_valid got=%b want=0", op_valid); end
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== exp_status(S_IDLE, 8'h00, 1'b0)) begin n_fail++; $display("FAIL abort_wins_status got=%h want=%h", rdv, exp_status(S_IDLE, 8'h00, 1'b0)); end
   endtask

   task automatic test_keep_abort();
      logic [31:0] rdv;
      logic [255:0] seen, first;
      logic vld;
      logic [27:0] r;
      for (int n = 0; n < 8; n++) m_data[n] = $urandom;
      first = m_vec();
      load_all();
      wb_write(A_CTRL, 32'hA, 4'hF);
      wb_read(A_CTRL, rdv);
      n_tests++; if (rdv !== {28'h0, IRQ_EN, 3'b010}) begin n_fail++; $display("FAIL ctrl_read got=%h want=%h", rdv, {28'h0, IRQ_EN, 3'b010}); end
      wb_write(A_CTRL, 32'hB, 4'hF);
      mac_accept($urandom_range(0, 3), seen, vld);
      n_tests++; if (seen !== first || vld !== 1'b1) begin n_fail++; $display("FAIL keep_vec1 got=%h want=%h", seen, first); end
      r = 28'($urandom);
      @(negedge clk);
      mac_result(r);
      n_tests++; if (irq !== IRQ_EN) begin n_fail++; $display("FAIL irq_done got=%b want=%b", irq, IRQ_EN); end
      wb_read(A_RESULT, rdv);
      n_tests++; if (rdv !== {4'h0, r}) begin n_fail++; $display("FAIL keep_result got=%h want=%h", rdv, {4'h0, r}); end
      n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%b want=0", irq); end
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== exp_status(S_IDLE, 8'hFF, 1'b0)) begin n_fail++; $display("FAIL keep_mask got=%h want=%h", rdv, exp_status(S_IDLE, 8'hFF, 1'b0)); end
      wb_write(A_CTRL, 32'hB, 4'hF);
      n_tests++; if (op_valid !== 1'b1 || op_data !== first) begin n_fail++; $display("FAIL keep_vec2 valid=%b got=%h want=%h", op_valid, op_data, first); end
      wb_write(A_CTRL, 32'hE, 4'hF);
      n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got=%b want=0", op_valid); end
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== exp_status(S_IDLE, 8'h00, 1'b0)) begin n_fail++; $display("FAIL abort_status got=%h want=%h", rdv, exp_status(S_IDLE, 8'h00, 1'b0)); end
      wb_read(A_RESULT, rdv);
      n_tests++; if (rdv !== {4'h0, r}) begin n_fail++; $display("FAIL abort_keeps_result got=%h want=%h", rdv, {4'h0, r}); end
      wb_write(A_CTRL, 32'h0, 4'hF);
   endtask

   task automatic test_random();
      logic [31:0] rdv, d;
      logic [255:0] seen;
      logic vld;
      logic [27:0] r;
      logic [3:0] s;
      int k;
      for (int it = 0; it < 8; it++) begin
         for (int n = 0; n < 8; n++) m_data[n] = $urandom;
         load_all();
         k = int'($urandom_range(0, 7));
         s = 4'($urandom_range(1, 15));
         d = $urandom;
         for (int b = 0; b < 4; b++) if (s[b]) m_data[k][8*b +: 8] = d[8*b +: 8];
         wb_write(a_data(k), d, s);
         k = int'($urandom_range(0, 7));
         wb_read(a_data(k), rdv);
         n_tests++; if (rdv !== m_data[k]) begin n_fail++; $display("FAIL rnd_data it%0d w%0d got=%h want=%h", it, k, rdv, m_data[k]); end
         wb_write(A_CTRL, 32'h1, 4'hF);
         mac_accept($urandom_range(0, 3), seen, vld);
         n_tests++; if (seen !== m_vec() || vld !== 1'b1) begin n_fail++; $display("FAIL rnd_vec it%0d got=%h want=%h", it, seen, m_vec()); end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         r = 28'($urandom);
         mac_result(r);
         wb_read(A_RESULT, rdv);
         n_tests++; if (rdv !== {4'h0, r}) begin n_fail++; $display("FAIL rnd_result it%0d got=%h want=%h", it, rdv, {4'h0, r}); end
         wb_read(A_STATUS, rdv);
         n_tests++; if (rdv !== exp_status(S_IDLE, 8'h00, 1'b0)) begin n_fail++; $display("FAIL rnd_status it%0d got=%h want=%h", it, rdv, exp_status(S_IDLE, 8'h00, 1'b0)); end
      end
   endtask

   task automatic test_reset_mid_issue();
      logic [31:0] rdv;
      load_all();
      wb_write(A_CTRL, 32'h1, 4'hF);
      n_tests++; if (op_valid !== 1'b1) begin n_fail++; $display("FAIL mid_issue_pre got=%b want=1", op_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got=%b want=0", op_valid); end
      n_tests++; if (op_data !== 256'h0) begin n_fail++; $display("FAIL mid_reset_data got=%h want=0", op_data); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got=%b want=0", op_valid); end
      wb_read(A_STATUS, rdv);
      n_tests++; if (rdv !== 32'h0) begin n_fail++; $display("FAIL post_reset_status got=%h want=0", rdv); end
      wb_read(A_RESULT, rdv);
      n_tests++; if (rdv !== 32'h0) begin n_fail++; $display("FAIL post_reset_result got=%h want=0", rdv); end
      wb_read(a_data(0), rdv);
      n_tests++; if (rdv !== 32'h0) begin n_fail++; $display("FAIL post_reset_data0 got=%h want=0", rdv); end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      rst_n = 1'b0;
      stb = 0; cyc = 0; we = 0; sel = '0; adr = '0; dat_w = '0;
      op_ready = 0; res_data = '0; res_valid = 0;
      for (int n = 0; n < 8; n++) m_data[n] = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_wb_protocol();
      test_issue();
      test_result();
      test_err();
      test_byte_write();
      test_keep_abort();
      test_random();
      test_reset_mid_issue();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

endmodule
